// File: rtl/seq_pkg.sv
// Shared types for the multicycle stage sequencer: state encoding and state width.
package seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd6
  } seq_state_e;

  // States that wait on mem_ready and are therefore covered by the timeout.
  function automatic logic is_mem_wait(input seq_state_e s);
    return (s == ST_IF) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/stage_sequencer_wait_timer.sv
// Memory wait timer: counts stalled cycles in a waiting state and flags the
// terminal count (MEM_TIMEOUT-1). Cleared whenever the sequencer changes state.
module wait_timer
  import seq_pkg::*;
#(
  parameter int TMO_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [TMO_W-1:0] TERM_CNT = TMO_W'(MEM_TIMEOUT - 1);

  logic [TMO_W-1:0] timer;

  // Stall cycle counter; clear has priority so a fresh state always starts at 0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (count) begin
      timer <= timer + 1'b1;
    end
  end

  assign expired = (timer == TERM_CNT);

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer: walks each instruction through IF/ID/EX/MEM/WB,
// owns the branch decision (pc_src) and the PC write strobe, and halts with a
// sticky mem_err if memory fails to respond in IF or MEM.
// Optional build macro PERF_CNT_EN adds instr_cnt / stall_cnt perf counters.
//
// state | meaning
// IDLE  | waiting for start
// IF    | instruction fetch, waits on mem_ready (timed)
// ID    | decode; halt_req sampled here
// EX    | execute; branch & alu_zero sampled into pc_src on exit
// MEM   | load/store access, waits on mem_ready (timed)
// WB    | write back; pc_write strobe
// HALT  | terminal until reset (halt instruction or memory timeout)
module stage_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               branch,
  input  logic               alu_zero,
  input  logic               mem_access,
  input  logic               mem_ready,
  input  logic               halt_req,
  output logic               if_en,
  output logic               id_en,
  output logic               ex_en,
  output logic               mem_en,
  output logic               wb_en,
  output logic               pc_write,
  output logic               pc_src,
  output logic               busy,
  output logic               halted,
  output logic               mem_err,
  output logic [STATE_W-1:0] state
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   instr_cnt,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);

  seq_state_e state_q;
  seq_state_e state_d;
  logic       tmo_expired;
  logic       tmo_clear;
  logic       tmo_count;
  logic       tmo_fire;

  // A state change restarts the wait timer; only stalled IF/MEM cycles advance it.
  assign tmo_clear = (state_d != state_q);
  assign tmo_count = is_mem_wait(state_q) && !mem_ready;

  wait_timer #(
    .TMO_W       (TMO_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmo_clear),
    .count   (tmo_count),
    .expired (tmo_expired)
  );

  // Next-state logic; mem_ready beats a simultaneous timer expiry.
  always_comb begin
    state_d  = state_q;
    tmo_fire = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_IF;
      ST_IF: begin
        if (mem_ready) begin
          state_d = ST_ID;
        end else if (tmo_expired) begin
          state_d  = ST_HALT;
          tmo_fire = 1'b1;
        end
      end
      ST_ID:   state_d = halt_req ? ST_HALT : ST_EX;
      ST_EX:   state_d = mem_access ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (mem_ready) begin
          state_d = ST_WB;
        end else if (tmo_expired) begin
          state_d  = ST_HALT;
          tmo_fire = 1'b1;
        end
      end
      ST_WB:   state_d = ST_IF;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, branch decision and sticky error registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_src  <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_EX) pc_src <= branch & alu_zero;
      if (tmo_fire) mem_err <= 1'b1;
    end
  end

`ifdef PERF_CNT_EN
  // Retired-instruction and memory-stall counters; HALT has no WB or wait cycles so both freeze.
  always_ff @(posedge clock) begin
    if (!reset) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (state_q == ST_WB) instr_cnt <= instr_cnt + 1'b1;
      if (tmo_count) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

  assign if_en    = (state_q == ST_IF);
  assign id_en    = (state_q == ST_ID);
  assign ex_en    = (state_q == ST_EX);
  assign mem_en   = (state_q == ST_MEM);
  assign wb_en    = (state_q == ST_WB);
  assign pc_write = (state_q == ST_WB);
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted   = (state_q == ST_HALT);
  assign state    = state_q;

endmodule
